// File: rtl/riscv_mtimer.sv
// RISC-V machine timer: 64-bit tick counter with compare interrupt behind an APB slave.
// MTIMEH reads return a snapshot of the high half latched by the most recent MTIME read.
module riscv_mtimer (
  input  logic        clk,
  input  logic        rst,
  input  logic        apbs_psel,
  input  logic        apbs_penable,
  input  logic        apbs_pwrite,
  input  logic [19:0] apbs_paddr,
  input  logic [31:0] apbs_pwdata,
  output logic [31:0] apbs_prdata,
  output logic        apbs_pready,
  output logic        apbs_pslverr,
  input  logic        mtime_tick_nrz,
  output logic        timer_irq
);

  typedef enum logic [2:0] {
    REG_CTRL   = 3'd0,
    REG_RSV0   = 3'd1,
    REG_MTIME  = 3'd2,
    REG_MTIMEH = 3'd3,
    REG_CMP    = 3'd4,
    REG_CMPH   = 3'd5,
    REG_RSV1   = 3'd6,
    REG_RSV2   = 3'd7
  } reg_sel_e;

  logic        en;
  logic [63:0] count;
  logic [63:0] cmp;
  logic [31:0] snap;
  logic        tick_q;

  reg_sel_e    sel;
  logic        access;
  logic        wr;
  logic        rd;
  logic        mapped;
  logic        tick_event;
  logic        unused_addr_bits;

  assign sel        = reg_sel_e'(apbs_paddr[4:2]);
  assign access     = apbs_psel & apbs_penable;
  assign wr         = access & apbs_pwrite;
  assign rd         = access & ~apbs_pwrite;
  assign tick_event = mtime_tick_nrz ^ tick_q;
  assign apbs_pready = 1'b1;
  assign unused_addr_bits = ^{apbs_paddr[19:5], apbs_paddr[1:0]};

  // NOTE: every signal driven in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    mapped = 1'b0;
    case (sel)
      REG_CTRL, REG_MTIME, REG_MTIMEH, REG_CMP, REG_CMPH: mapped = 1'b1;
      default:                                          mapped = 1'b0;
    endcase
  end

  assign apbs_pslverr = access & ~mapped;

  // Read data is live whenever selected; zero otherwise so the bus mux stays clean.
  always_comb begin
    apbs_prdata = 32'h0;
    if (apbs_psel) begin
      case (sel)
        REG_CTRL:   apbs_prdata = {23'h0, timer_irq, 7'h0, en};
        REG_MTIME:  apbs_prdata = count[31:0];
        REG_MTIMEH: apbs_prdata = snap;
        REG_CMP:    apbs_prdata = cmp[31:0];
        REG_CMPH:   apbs_prdata = cmp[63:32];
        default:    apbs_prdata = 32'h0;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values, which the compare relies on.
  always_ff @(posedge clk) begin
    if (rst) begin
      en        <= 1'b0;
      count     <= 64'h0;
      cmp       <= '1;
      snap      <= 32'h0;
      tick_q    <= 1'b0;
      timer_irq <= 1'b0;
    end else begin
      tick_q    <= mtime_tick_nrz;
      timer_irq <= (count >= cmp);

      if (wr && sel == REG_CTRL)
        en <= apbs_pwdata[0];
      if (wr && sel == REG_CMP)
        cmp[31:0] <= apbs_pwdata;
      if (wr && sel == REG_CMPH)
        cmp[63:32] <= apbs_pwdata;

      // A software write to either half swallows a coincident tick entirely.
      if (wr && sel == REG_MTIME)
        count[31:0] <= apbs_pwdata;
      else if (wr && sel == REG_MTIMEH)
        count[63:32] <= apbs_pwdata;
      else if (tick_event && en)
        count <= count + 64'd1;

      if (rd && sel == REG_MTIME)
        snap <= count[63:32];
    end
  end

endmodule

// File: tb/tb_riscv_mtimer.sv
// Directed self-checking bench for riscv_mtimer: counting, carry, snapshot coherence,
// interrupt latency, write/tick collisions, unmapped accesses and mid-transfer reset.
module tb_riscv_mtimer;

  localparam logic [19:0] A_CTRL   = 20'h00;
  localparam logic [19:0] A_RSV0   = 20'h04;
  localparam logic [19:0] A_MTIME  = 20'h08;
  localparam logic [19:0] A_MTIMEH = 20'h0C;
  localparam logic [19:0] A_CMP    = 20'h10;
  localparam logic [19:0] A_CMPH   = 20'h14;
  localparam logic [19:0] A_RSV1   = 20'h18;

  logic        clk;
  logic        rst;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [19:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;
  logic        nrz;
  logic        irq;

  int n_tests = 0;
  int n_fail  = 0;

  riscv_mtimer dut (
    .clk            (clk),
    .rst            (rst),
    .apbs_psel      (psel),
    .apbs_penable   (penable),
    .apbs_pwrite    (pwrite),
    .apbs_paddr     (paddr),
    .apbs_pwdata    (pwdata),
    .apbs_prdata    (prdata),
    .apbs_pready    (pready),
    .apbs_pslverr   (pslverr),
    .mtime_tick_nrz (nrz),
    .timer_irq      (irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tick();
    nrz = ~nrz;
    idle(1);
  endtask

  task automatic apb_write(input logic [19:0] addr, input logic [31:0] data,
                           input logic flip, output logic err);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = addr; pwdata = data;
    idle(1);
    penable = 1'b1;
    if (flip) nrz = ~nrz;
    #3;
    err = pslverr;
    idle(1);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic wr(input logic [19:0] addr, input logic [31:0] data);
    logic e;
    apb_write(addr, data, 1'b0, e);
  endtask

  task automatic apb_read(input logic [19:0] addr, output logic [31:0] data, output logic err);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = addr;
    idle(1);
    penable = 1'b1;
    #3;
    data = prdata;
    err  = pslverr;
    idle(1);
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [19:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    logic        e;
    apb_read(addr, d, e);
    check(tag, d, exp);
  endtask

  initial begin
    logic [31:0] d;
    logic        e;

    rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; nrz = 1'b0;
    idle(3);
    rst = 1'b0;

    // Reset state
    check("rst_irq", {31'h0, irq}, 32'h0);
    check("rst_pslverr", {31'h0, pslverr}, 32'h0);
    check("rst_prdata", prdata, 32'h0);
    check("rst_pready", {31'h0, pready}, 32'h1);
    rd_chk("rst_ctrl", A_CTRL, 32'h0);
    rd_chk("rst_mtime", A_MTIME, 32'h0);
    rd_chk("rst_cmp", A_CMP, 32'hffff_ffff);
    rd_chk("rst_cmph", A_CMPH, 32'hffff_ffff);

    // Five slow ticks
    wr(A_CTRL, 32'h1);
    for (int i = 0; i < 5; i++) begin
      tick();
      idle(2);
    end
    apb_read(A_MTIME, d, e);
    check("slow_mtime", d, 32'd5);
    check("mapped_pslverr", {31'h0, e}, 32'h0);
    rd_chk("slow_mtimeh", A_MTIMEH, 32'h0);
    check("slow_irq", {31'h0, irq}, 32'h0);
    rd_chk("ctrl_en", A_CTRL, 32'h1);

    // Back-to-back ticks, then the same with EN=0
    wr(A_MTIME, 32'h0);
    for (int i = 0; i < 8; i++) tick();
    rd_chk("fast_mtime", A_MTIME, 32'd8);
    wr(A_CTRL, 32'h0);
    for (int i = 0; i < 8; i++) tick();
    rd_chk("disabled_mtime", A_MTIME, 32'd8);
    wr(A_CTRL, 32'h1);

    // Carry into the high half
    wr(A_MTIMEH, 32'h0);
    wr(A_MTIME, 32'hffff_fffe);
    tick();
    tick();
    rd_chk("carry_lo", A_MTIME, 32'h0);
    rd_chk("carry_hi", A_MTIMEH, 32'h1);

    // Snapshot coherence
    wr(A_MTIMEH, 32'h0);
    wr(A_MTIME, 32'hffff_ffff);
    rd_chk("snap_lo", A_MTIME, 32'hffff_ffff);
    tick();
    rd_chk("snap_hi", A_MTIMEH, 32'h0);
    rd_chk("live_lo", A_MTIME, 32'h0);
    rd_chk("live_hi", A_MTIMEH, 32'h1);

    // Interrupt latency and clear via cmp
    wr(A_MTIMEH, 32'h0);
    wr(A_MTIME, 32'h0);
    wr(A_CMP, 32'd3);
    wr(A_CMPH, 32'h0);
    idle(1);
    check("irq_below", {31'h0, irq}, 32'h0);
    tick();
    tick();
    tick();
    check("irq_same_edge", {31'h0, irq}, 32'h0);
    idle(1);
    check("irq_next_edge", {31'h0, irq}, 32'h1);
    rd_chk("ctrl_irq", A_CTRL, 32'h101);
    wr(A_CMP, 32'd10);
    check("irq_hold_on_write", {31'h0, irq}, 32'h1);
    idle(1);
    check("irq_cleared", {31'h0, irq}, 32'h0);

    // Write/tick collisions
    apb_write(A_MTIME, 32'h100, 1'b1, e);
    rd_chk("coll_lo", A_MTIME, 32'h100);
    rd_chk("coll_lo_hi", A_MTIMEH, 32'h0);
    apb_write(A_MTIMEH, 32'h5, 1'b1, e);
    rd_chk("collh_lo", A_MTIME, 32'h100);
    rd_chk("collh_hi", A_MTIMEH, 32'h5);

    // Unmapped offsets
    apb_read(A_RSV1, d, e);
    check("rsv18_prdata", d, 32'h0);
    check("rsv18_rd_err", {31'h0, e}, 32'h1);
    apb_write(A_RSV1, 32'hdead_beef, 1'b0, e);
    check("rsv18_wr_err", {31'h0, e}, 32'h1);
    apb_read(A_RSV0, d, e);
    check("rsv04_rd_err", {31'h0, e}, 32'h1);
    rd_chk("rsv_cmp_kept", A_CMP, 32'd10);
    rd_chk("rsv_mtime_kept", A_MTIME, 32'h100);
    check("idle_pslverr", {31'h0, pslverr}, 32'h0);

    // 64-bit wrap, upper address bits ignored
    wr(A_MTIMEH, 32'hffff_ffff);
    wr(A_MTIME, 32'hffff_ffff);
    tick();
    rd_chk("wrap_lo", 20'hABC08, 32'h0);
    rd_chk("wrap_hi", A_MTIMEH, 32'h0);
    check("wrap_irq", {31'h0, irq}, 32'h0);

    // Reset during an access phase drops the write
    wr(A_MTIME, 32'h77);
    idle(1);
    check("pre_rst_irq", {31'h0, irq}, 32'h1);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = A_CMP; pwdata = 32'h55;
    idle(1);
    penable = 1'b1;
    rst = 1'b1;
    nrz = 1'b0;
    idle(1);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; rst = 1'b0;
    check("mid_rst_irq", {31'h0, irq}, 32'h0);
    rd_chk("mid_rst_cmp", A_CMP, 32'hffff_ffff);
    rd_chk("mid_rst_ctrl", A_CTRL, 32'h0);
    rd_chk("mid_rst_mtime", A_MTIME, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
